// File: rtl/soft_max_pkg.sv
// Shared definitions for the softmax max/sum accumulation controller:
// FSM state encoding and default datapath widths.
package soft_max_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/soft_max_acc_ctrl_if.sv
// Bundle of control, score-stream, external-PE and result signals of the
// accumulation controller; slave is the controller, master its environment.
interface soft_max_acc_ctrl_if #(
  parameter int DATA_WIDTH = soft_max_pkg::DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = soft_max_pkg::DEF_CNT_WIDTH
);
  logic                         start;
  logic [CNT_WIDTH-1:0]         num_elem;
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] pe_in1;
  logic signed [DATA_WIDTH-1:0] pe_in2;
  logic                         pe_set_reg;
  logic signed [DATA_WIDTH-1:0] pe_psum_out;
  logic signed [DATA_WIDTH-1:0] sum_out;
  logic signed [DATA_WIDTH-1:0] max_out;
  logic                         result_valid;
  logic                         busy;
  logic                         zero_len;

  modport slave (
    input  start, num_elem, in_valid, in_data, pe_psum_out,
    output in_ready, pe_in1, pe_in2, pe_set_reg,
           sum_out, max_out, result_valid, busy, zero_len
  );

  modport master (
    output start, num_elem, in_valid, in_data, pe_psum_out,
    input  in_ready, pe_in1, pe_in2, pe_set_reg,
           sum_out, max_out, result_valid, busy, zero_len
  );
endinterface

// File: rtl/sm_max_track.sv
// Running-maximum register: cleared when a reduction starts, loaded by the
// first accepted score, then replaced by any strictly larger signed score.
module sm_max_track
  import soft_max_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         update,
  input  logic                         first,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic signed [DATA_WIDTH-1:0] max_val
);

  logic signed [DATA_WIDTH-1:0] max_q, max_d;

  // NOTE: max_d gets its hold value before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    max_d = max_q;
    if (clear) begin
      max_d = '0;
    end else if (update && (first || data > max_q)) begin
      max_d = data;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) max_q <= '0;
    else       max_q <= max_d;
  end

  assign max_val = max_q;

endmodule

// File: rtl/soft_max_acc_ctrl.sv
// Sequences one max/sum reduction over a score stream, driving an external
// registered adder PE and tracking the running maximum in sm_max_track.
module soft_max_acc_ctrl
  import soft_max_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,  // active-high despite the legacy name
  soft_max_acc_ctrl_if.slave bus
);

  state_e                       state_q, state_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         num_q, num_d;
  logic signed [DATA_WIDTH-1:0] sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] max_out_q, max_out_d;
  logic                         rv_q, rv_d;
  logic                         zl_q, zl_d;
  logic signed [DATA_WIDTH-1:0] run_max;

  logic start_ok, accept, first_beat, last_beat, zero_run;

  assign start_ok   = (state_q == S_IDLE || state_q == S_DONE) && bus.start;
  assign accept     = (state_q == S_ACCUM) && bus.in_valid;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = ((cnt_q + CNT_WIDTH'(1)) == num_q);
  assign zero_run   = (num_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    sum_d     = sum_q;
    max_out_d = max_out_q;
    rv_d      = rv_q;
    zl_d      = zl_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          num_d   = bus.num_elem;
          cnt_d   = '0;
          rv_d    = 1'b0;
          zl_d    = 1'b0;
          state_d = (bus.num_elem == '0) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (last_beat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The PE register holds the complete sum by now (one cycle after the last beat).
        sum_d     = zero_run ? '0 : bus.pe_psum_out;
        max_out_d = zero_run ? '0 : run_max;
        zl_d      = zero_run;
        rv_d      = 1'b1;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      sum_q     <= '0;
      max_out_q <= '0;
      rv_q      <= 1'b0;
      zl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      sum_q     <= sum_d;
      max_out_q <= max_out_d;
      rv_q      <= rv_d;
      zl_q      <= zl_d;
    end
  end

  sm_max_track #(.DATA_WIDTH(DATA_WIDTH)) u_max_track (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok),
    .update  (accept),
    .first   (first_beat),
    .data    (bus.in_data),
    .max_val (run_max)
  );

  // The first beat seeds the PE with zero so a stale sum never leaks in.
  assign bus.in_ready     = (state_q == S_ACCUM);
  assign bus.pe_set_reg   = accept;
  assign bus.pe_in1       = accept ? bus.in_data : '0;
  assign bus.pe_in2       = (accept && !first_beat) ? bus.pe_psum_out : '0;
  assign bus.busy         = (state_q == S_ACCUM) || (state_q == S_DRAIN);
  assign bus.sum_out      = sum_q;
  assign bus.max_out      = max_out_q;
  assign bus.result_valid = rv_q;
  assign bus.zero_len     = zl_q;

endmodule

// File: tb/tb_soft_max_acc_ctrl.sv
// Scoreboard bench for soft_max_acc_ctrl: a driver pushes the expected
// sum/max/latency of each reduction, a monitor pops it when a result appears.
module tb_soft_max_acc_ctrl;

  localparam int DW = 16;
  localparam int CW = 8;

  typedef struct {
    logic signed [DW-1:0] sum;
    logic signed [DW-1:0] mx;
    logic                 zl;
    int                   last_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   nvec;
  int   nerr;
  exp_t sb[$];

  soft_max_acc_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  soft_max_acc_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External registered adder PE, reset by the same signal as the controller.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n)               bus.pe_psum_out <= '0;
    else if (bus.pe_set_reg) bus.pe_psum_out <= bus.pe_in1 + bus.pe_in2;
  end

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: result pops on every rising result_valid; idle PE drive checked each cycle.
  initial begin
    logic rv_prev;
    exp_t e;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.in_valid) begin
        check("pe_set_reg_idle", bus.pe_set_reg, 0);
        check("pe_in1_idle", bus.pe_in1, 0);
        check("pe_in2_idle", bus.pe_in2, 0);
      end
      if (bus.result_valid && !rv_prev) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_result: result_valid rose with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("sum_out", bus.sum_out, e.sum);
          check("max_out", bus.max_out, e.mx);
          check("zero_len", bus.zero_len, e.zl);
          check("latency_cycle", cyc, e.last_cyc + 2);
        end
      end
      rv_prev = bus.result_valid;
    end
  end

  // Driver tasks start and end 1 time unit after a rising edge.
  task automatic do_start(input int n, output int start_cyc);
    bus.start    = 1'b1;
    bus.num_elem = CW'(n);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic poke_start();
    bus.start    = 1'b1;
    bus.num_elem = CW'(1);
    @(negedge clk);
    check("busy_in_accum", bus.busy, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic signed [DW-1:0] d, input int gap,
                           input logic signed [DW-1:0] partial, output int acc_cyc);
    bit acc;
    acc = 1'b0;
    acc_cyc = -100;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        check("pe_set_reg_beat", bus.pe_set_reg, 1);
        check("pe_in1_beat", bus.pe_in1, d);
        check("pe_in2_beat", bus.pe_in2, partial);
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      nvec++;
      nerr++;
      $display("FAIL beat_accept_timeout: beat %0d not accepted within 50 cycles", d);
    end
  endtask

  task automatic wait_result(input exp_t e, input bit zero);
    for (int t = 0; t < 30 && sb.size() != 0; t++) begin
      @(negedge clk);
      if (zero) check("in_ready_zero_len", bus.in_ready, 0);
    end
    if (sb.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL result_timeout: no result_valid within 30 cycles");
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check("result_valid_hold", bus.result_valid, 1);
    check("sum_out_hold", bus.sum_out, e.sum);
    check("max_out_hold", bus.max_out, e.mx);
    @(posedge clk); #1;
  endtask

  // Reference: wrapped sum and signed maximum of the whole score list.
  task automatic run_vector(input int vals[$], input int gap_min, input int gap_max,
                            input int poke_at);
    int n, start_cyc, acc_cyc, last_cyc, total, mx;
    logic signed [DW-1:0] partial;
    exp_t e;
    n = vals.size();
    do_start(n, start_cyc);
    partial  = '0;
    last_cyc = start_cyc;
    for (int i = 0; i < n; i++) begin
      if (i == poke_at) poke_start();
      send_beat(DW'(vals[i]), int'($urandom_range(gap_max, gap_min)), partial, acc_cyc);
      last_cyc = acc_cyc;
      partial  = partial + DW'(vals[i]);
    end
    total = 0;
    mx    = (n > 0) ? vals[0] : 0;
    foreach (vals[i]) begin
      total += vals[i];
      if (vals[i] > mx) mx = vals[i];
    end
    e.sum      = DW'(total);
    e.mx       = DW'(mx);
    e.zl       = (n == 0);
    e.last_cyc = last_cyc;
    sb.push_back(e);
    wait_result(e, n == 0);
  endtask

  initial begin
    int vals[$];
    int sc;
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.num_elem = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_pe_set_reg", bus.pe_set_reg, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_zero_len", bus.zero_len, 0);
    check("rst_sum_out", bus.sum_out, 0);
    check("rst_max_out", bus.max_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Back-to-back 3,-1,7,2.
    vals.delete();
    vals.push_back(3); vals.push_back(-1); vals.push_back(7); vals.push_back(2);
    run_vector(vals, 0, 0, -1);

    // 5,5,5 with three idle cycles before each beat.
    vals.delete();
    vals.push_back(5); vals.push_back(5); vals.push_back(5);
    run_vector(vals, 3, 3, -1);

    // Wrapping sum.
    vals.delete();
    vals.push_back(32767); vals.push_back(1);
    run_vector(vals, 0, 0, -1);

    // Zero-length reduction.
    vals.delete();
    run_vector(vals, 0, 0, -1);

    // Start pulsed mid-reduction after two beats must be ignored.
    vals.delete();
    vals.push_back(1); vals.push_back(2); vals.push_back(3); vals.push_back(4);
    run_vector(vals, 0, 0, 2);

    // Reset after two of four beats, then a fresh two-beat run.
    do_start(4, sc);
    send_beat(DW'(10), 0, DW'(0), sc);
    send_beat(DW'(20), 0, DW'(10), sc);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_result_valid", bus.result_valid, 0);
    check("abort_max_out", bus.max_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vals.delete();
    vals.push_back(-4); vals.push_back(-9);
    run_vector(vals, 0, 0, -1);

    // Randomized reductions, negative scores and gaps included.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(8, 1));
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(65535, 0)) - 32768);
      run_vector(vals, 0, 2, (r == 3) ? 1 : -1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/soft_max_acc_ctrl.md
SOFT_MAX_ACC_CTRL -- requirements
Module: soft_max_acc_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of scores, partial sums and results.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8: width of the element count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset (asserted = 1 despite the name).
REQ-005 The block SHALL have port start, input, 1 bit: begins one reduction; sampled only in IDLE or DONE.
REQ-006 The block SHALL have port num_elem, input, CNT_WIDTH: number of scores in the vector, latched on accepted start.
REQ-007 The block SHALL have ports in_valid (input, 1), in_data (input, signed DATA_WIDTH) and in_ready (output, 1): score stream.
REQ-008 The block SHALL have ports pe_in1 and pe_in2 (output, signed DATA_WIDTH) and pe_set_reg (output, 1): drive of the external adder PE.
REQ-009 The block SHALL have port pe_psum_out, input, signed DATA_WIDTH: registered PE sum, valid one cycle after pe_set_reg.
REQ-010 The block SHALL have ports sum_out and max_out (output, signed DATA_WIDTH), result_valid (output, 1), busy (output, 1) and zero_len (output, 1).

Function
REQ-011 The FSM SHALL have states IDLE, ACCUM, DRAIN and DONE.
REQ-012 IDLE or DONE with start=1 SHALL latch num_elem, clear the element counter and result_valid, and go to ACCUM; num_elem=0 goes to DRAIN instead.
REQ-013 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid and in_ready are both 1.
REQ-014 On each accepted beat: pe_set_reg=1, pe_in1=in_data, pe_in2=0 for the first beat, otherwise pe_in2=pe_psum_out; with no accepted beat, pe_set_reg=0 and pe_in1=pe_in2=0.
REQ-015 The running maximum SHALL load in_data on the first beat and then update to in_data when in_data > max (signed compare).
REQ-016 Accepting beat number num_elem SHALL move to DRAIN; in_valid gaps stall ACCUM indefinitely, with no timeout.
REQ-017 DRAIN SHALL last one cycle, then register sum_out=pe_psum_out and max_out=running max, and enter DONE with result_valid=1.
REQ-018 Latency: last beat accepted in cycle k gives result_valid=1 in cycle k+2.
REQ-019 result_valid, sum_out and max_out SHALL hold in DONE until the next accepted start.
REQ-020 Summation SHALL wrap modulo 2^DATA_WIDTH (the PE adder width), with no saturation.
REQ-021 num_elem=0 SHALL give sum_out=0, max_out=0 and zero_len=1 in DONE; otherwise zero_len=0.
REQ-022 busy SHALL be 1 in ACCUM and DRAIN; start in those states SHALL be ignored.

Reset
REQ-023 Reset SHALL force IDLE, clear counters and the running max, and drive all outputs to 0, including in_ready, pe_set_reg and result_valid.
REQ-024 Reset mid-reduction SHALL discard the partial result; the PE register is reset by the same rst_n.

Structure
REQ-025 Package soft_max_pkg SHALL hold the state encoding (2-bit, IDLE=0, ACCUM=1, DRAIN=2, DONE=3) and default DATA_WIDTH/CNT_WIDTH constants.
REQ-026 The PE SHALL stay external; one sub-module, sm_max_track, SHALL hold the running-maximum register and compare.

Verification
REQ-027 num_elem=4, scores 3,-1,7,2 back-to-back -> sum_out=11, max_out=7, result_valid two cycles after the 4th beat.
REQ-028 num_elem=3, scores 5,5,5 with in_valid low for 3 cycles between beats -> pe_set_reg only on accepted beats; sum=15, max=5.
REQ-029 num_elem=2, scores 32767,1 -> sum_out=-32768 (wrap), max_out=32767.
REQ-030 num_elem=0 -> DRAIN then DONE, zero_len=1, sum_out=0, max_out=0, in_ready never 1.
REQ-031 start pulsed in ACCUM after 2 of 4 beats -> ignored; result covers the original 4 beats.
REQ-032 rst_n=1 after 2 of 4 beats, then start with num_elem=2, scores -4,-9 -> sum_out=-13, max_out=-4, no carry-over from the aborted run.
